// File: rtl/lpf_sched_pkg.sv
// Shared types and default sizing for the time-shared moving-average scheduler.
package lpf_sched_pkg;

    localparam int N_CH_DEF         = 4;
    localparam int LOG2_WIN_MAX_DEF = 5;
    localparam int DW_DEF           = 32;
    localparam int SUM_W_DEF        = DW_DEF + LOG2_WIN_MAX_DEF;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_READ   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Running sum needs LOG2_WIN_MAX guard bits above the sample width.
    function automatic int sum_width(input int dw, input int log2_win_max);
        return dw + log2_win_max;
    endfunction

endpackage

// File: rtl/lpf_sched_hist_ram.sv
// Per-channel sample history: simple dual-port RAM, synchronous write, 1-cycle registered read.
module lpf_sched_hist_ram #(
    parameter int DEPTH = 128,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/lpf_mux_scheduler.sv
// Round-robin shared moving-average filter over N_CH channels, window 2^k selectable at runtime.
// Optional o_settled output when LPF_MUX_SCHEDULER_SETTLED_EN is defined.
module lpf_mux_scheduler
    import lpf_sched_pkg::*;
#(
    parameter int N_CH         = N_CH_DEF,
    parameter int LOG2_WIN_MAX = LOG2_WIN_MAX_DEF,
    parameter int DW           = DW_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_RESET,
    input  logic [N_CH-1:0]         i_req,
    input  logic [N_CH*DW-1:0]      i_data,
    input  logic [2:0]              i_log2_win,
    output logic [N_CH-1:0]         o_ack,
    output logic                    o_valid,
    output logic [$clog2(N_CH)-1:0] o_ch,
    output logic [DW-1:0]           o_mean,
    output logic                    o_busy
`ifdef LPF_MUX_SCHEDULER_SETTLED_EN
    ,
    output logic                    o_settled
`endif
);

    localparam int CW    = $clog2(N_CH);
    localparam int LW    = LOG2_WIN_MAX;
    localparam int AW    = CW + LW;
    localparam int SW    = sum_width(DW, LW);
    localparam int DEPTH = N_CH << LW;
    localparam int FW    = LW + 1;

    state_t                 state_reg;
    logic [2:0]             k_reg;
    logic [CW-1:0]          rr_reg;
    logic [CW-1:0]          g_reg;
    logic [AW-1:0]          clr_addr_reg;
    logic signed [DW-1:0]   new_reg;
    logic signed [DW-1:0]   old_reg;
    logic signed [SW-1:0]   sum_reg [N_CH];
    logic [LW-1:0]          idx_reg [N_CH];

    logic [DW-1:0]          data_ch [N_CH];
    logic [N_CH-1:0]        req_rot;
    logic [CW-1:0]          grant_off;
    logic [CW-1:0]          grant;
    logic                   grant_valid;
    logic                   k_change;

    logic [FW-1:0]          win_size;
    logic [LW-1:0]          win_mask;
    logic signed [SW-1:0]   new_ext;
    logic signed [SW-1:0]   old_ext;
    logic signed [SW-1:0]   new_sum;
    logic signed [SW-1:0]   mean_full;

    logic                   ram_we;
    logic [AW-1:0]          ram_waddr;
    logic [DW-1:0]          ram_wdata;
    logic [AW-1:0]          ram_raddr;
    logic [DW-1:0]          ram_rdata;

    // Unpack samples and rotate requests so offset 0 is the round-robin pointer.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign data_ch[gi] = i_data[gi*DW +: DW];
            assign req_rot[gi] = i_req[rr_reg + CW'(gi)];
        end
    endgenerate

    always_comb begin
        grant_off   = '0;
        grant_valid = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_off   = CW'(i);
                grant_valid = 1'b1;
            end
        end
    end

    assign grant    = rr_reg + grant_off;
    assign k_change = (i_log2_win != k_reg);

    assign win_size  = FW'(1) << k_reg;
    assign win_mask  = LW'(win_size - FW'(1));
    assign new_ext   = {{LW{new_reg[DW-1]}}, new_reg};
    assign old_ext   = {{LW{old_reg[DW-1]}}, old_reg};
    assign new_sum   = sum_reg[g_reg] + new_ext - old_ext;
    assign mean_full = sum_reg[g_reg] >>> k_reg;

    // Writes are gated by reset so a sample caught mid-slot never lands in the history.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr_reg;
        ram_wdata = '0;
        ram_raddr = {grant, idx_reg[grant]};
        if (i_RESET) begin
            if (state_reg == ST_CLEAR) begin
                ram_we = 1'b1;
            end else if (state_reg == ST_UPDATE) begin
                ram_we    = 1'b1;
                ram_waddr = {g_reg, idx_reg[g_reg]};
                ram_wdata = new_reg;
            end
        end
    end

    lpf_sched_hist_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_hist_ram (
        .i_clock (i_clock),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (!i_RESET) begin
            state_reg    <= ST_CLEAR;
            k_reg        <= i_log2_win;
            rr_reg       <= '0;
            g_reg        <= '0;
            clr_addr_reg <= '0;
            new_reg      <= '0;
            old_reg      <= '0;
            o_ack        <= '0;
            o_valid      <= 1'b0;
            o_ch         <= '0;
            o_mean       <= '0;
            o_busy       <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                sum_reg[c] <= '0;
                idx_reg[c] <= '0;
            end
        end else begin
            o_ack   <= '0;
            o_valid <= 1'b0;
            case (state_reg)
                ST_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + AW'(1);
                    if (clr_addr_reg == AW'(DEPTH - 1)) begin
                        state_reg <= ST_IDLE;
                        o_busy    <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (k_change) begin
                        k_reg        <= i_log2_win;
                        clr_addr_reg <= '0;
                        o_busy       <= 1'b1;
                        state_reg    <= ST_CLEAR;
                        for (int c = 0; c < N_CH; c++) begin
                            sum_reg[c] <= '0;
                            idx_reg[c] <= '0;
                        end
                    end else if (grant_valid) begin
                        g_reg     <= grant;
                        new_reg   <= data_ch[grant];
                        o_ack     <= N_CH'(1) << grant;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_reg   <= ram_rdata;
                    state_reg <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    sum_reg[g_reg] <= new_sum;
                    idx_reg[g_reg] <= (idx_reg[g_reg] + LW'(1)) & win_mask;
                    rr_reg         <= g_reg + CW'(1);
                    state_reg      <= ST_OUT;
                end
                ST_OUT: begin
                    o_valid   <= 1'b1;
                    o_ch      <= g_reg;
                    o_mean    <= mean_full[DW-1:0];
                    state_reg <= ST_IDLE;
                end
                default: begin
                    clr_addr_reg <= '0;
                    o_busy       <= 1'b1;
                    state_reg    <= ST_CLEAR;
                end
            endcase
        end
    end

`ifdef LPF_MUX_SCHEDULER_SETTLED_EN
    logic [FW-1:0] fill_reg [N_CH];

    // Fill counts track accepted samples since the last clear, saturating at the window length.
    always_ff @(posedge i_clock) begin
        if (!i_RESET) begin
            o_settled <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                fill_reg[c] <= '0;
            end
        end else begin
            o_settled <= 1'b0;
            if (state_reg == ST_IDLE && k_change) begin
                for (int c = 0; c < N_CH; c++) begin
                    fill_reg[c] <= '0;
                end
            end else if (state_reg == ST_UPDATE) begin
                if (fill_reg[g_reg] < win_size) begin
                    fill_reg[g_reg] <= fill_reg[g_reg] + FW'(1);
                end
            end else if (state_reg == ST_OUT) begin
                o_settled <= (fill_reg[g_reg] >= win_size);
            end
        end
    end
`else
    // No fill tracking: results carry no settled indication.
`endif

endmodule

// File: tb/tb_lpf_mux_scheduler.sv
// Scoreboard bench for lpf_mux_scheduler: stimulus pushes expected results, a forked monitor checks them.
module tb_lpf_mux_scheduler;

    logic         i_clock = 1'b0;
    logic         i_RESET = 1'b0;
    logic [3:0]   i_req = '0;
    logic [127:0] i_data = '0;
    logic [2:0]   i_log2_win = 3'd2;
    logic [3:0]   o_ack;
    logic         o_valid;
    logic [1:0]   o_ch;
    logic [31:0]  o_mean;
    logic         o_busy;
`ifdef LPF_MUX_SCHEDULER_SETTLED_EN
    logic         o_settled;
`endif

    lpf_mux_scheduler dut (
        .i_clock    (i_clock),
        .i_RESET    (i_RESET),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_log2_win (i_log2_win),
        .o_ack      (o_ack),
        .o_valid    (o_valid),
        .o_ch       (o_ch),
        .o_mean     (o_mean),
        .o_busy     (o_busy)
`ifdef LPF_MUX_SCHEDULER_SETTLED_EN
        ,
        .o_settled  (o_settled)
`endif
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        int     ch;
        longint mean;
        bit     settled;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_cyc = 0;
    bit   ack_in_busy = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge i_clock);
            if (o_ack != 4'd0) ack_cyc = cyc;
            if (o_busy && o_ack != 4'd0) ack_in_busy = 1'b1;
            if (o_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual ch=%0d mean=%0d required=none", o_ch, $signed(o_mean));
                end else begin
                    e = q.pop_front();
                    $display("txn ch=%0d mean=%0d (expected ch=%0d mean=%0d)", o_ch, $signed(o_mean), e.ch, e.mean);
                    chk("result_ch", longint'(o_ch), longint'(e.ch));
                    chk("result_mean", longint'($signed(o_mean)), e.mean);
                    chk("ack_to_valid_latency", longint'(cyc - ack_cyc), 64'sd3);
`ifdef LPF_MUX_SCHEDULER_SETTLED_EN
                    chk("result_settled", longint'(o_settled), longint'(e.settled));
`endif
                end
            end
        end
    endtask

    task automatic send(input int ch, input logic [31:0] val, input longint m, input bit s, input bit push);
        bit got = 1'b0;
        exp_t e;
        i_data[ch*32 +: 32] = val;
        i_req[ch] = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge i_clock);
            if (o_ack[ch]) begin
                got = 1'b1;
                break;
            end
        end
        i_req[ch] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=no_ack required=ack ch=%0d", ch);
        end else if (push) begin
            e.ch = ch;
            e.mean = m;
            e.settled = s;
            q.push_back(e);
        end
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        int t = 0;
        while (!o_busy && t < 20) begin
            @(negedge i_clock);
            t++;
        end
        while (o_busy && n < 1000) begin
            n++;
            @(negedge i_clock);
        end
        chk(name, longint'(n), 64'sd128);
    endtask

    initial begin
        int     order [5] = '{0, 1, 2, 3, 0};
        longint em    [5] = '{76, 2, 7, 9, 52};
        bit     es    [5] = '{1, 0, 0, 0, 1};
        int     n;
        int     last;
        int     ch;
        exp_t   e;

        fork
            monitor();
        join_none

        // Reset with k=2; ch2 requests through the whole clear.
        repeat (3) @(negedge i_clock);
        chk("reset_busy", longint'(o_busy), 64'sd1);
        chk("reset_valid", longint'(o_valid), 64'sd0);
        chk("reset_ack", longint'(o_ack), 64'sd0);
        chk("reset_ch", longint'(o_ch), 64'sd0);
        chk("reset_mean", longint'(o_mean), 64'sd0);
        i_data[2*32 +: 32] = 32'd40;
        i_req[2] = 1'b1;
        i_RESET = 1'b1;
        wait_clear("init_clear_cycles");
        chk("no_ack_while_busy", longint'(ack_in_busy), 64'sd0);
        send(2, 32'd40, 10, 1'b0, 1'b1);

        // Warm-up at k=2 and steady state.
        send(0, 32'd100, 25, 1'b0, 1'b1);
        send(0, 32'd100, 50, 1'b0, 1'b1);
        send(0, 32'd100, 75, 1'b0, 1'b1);
        send(0, 32'd100, 100, 1'b1, 1'b1);
        send(0, 32'd100, 100, 1'b1, 1'b1);
        send(3, 32'd16, 4, 1'b0, 1'b1);

        // All four requesting: round-robin order and 4-cycle spacing.
        i_data = {32'd20, 32'hFFFF_FFF4, 32'd8, 32'd4};
        i_req = 4'hF;
        n = 0;
        last = 0;
        for (int t = 0; t < 100 && n < 5; t++) begin
            @(negedge i_clock);
            if (o_ack != 4'd0) begin
                ch = -1;
                for (int b = 0; b < 4; b++) if (o_ack[b]) ch = b;
                chk("rr_order", longint'(ch), longint'(order[n]));
                if (n > 0) chk("rr_spacing", longint'(cyc - last), 64'sd4);
                last = cyc;
                e.ch = order[n];
                e.mean = em[n];
                e.settled = es[n];
                q.push_back(e);
                n++;
            end
        end
        i_req = 4'h0;
        chk("rr_ack_count", longint'(n), 64'sd5);

        // Window change mid-stream: slot completes, then a full clear.
        send(1, 32'd8, 4, 1'b0, 1'b1);
        i_log2_win = 3'd3;
        wait_clear("k3_clear_cycles");
        send(0, 32'd80, 10, 1'b0, 1'b1);

        i_log2_win = 3'd1;
        wait_clear("k1_clear_cycles");
        send(1, 32'hFFFF_FFF9, -4, 1'b0, 1'b1);

        i_log2_win = 3'd0;
        wait_clear("k0_clear_cycles");
        send(1, 32'hFFFF_FFF9, -7, 1'b1, 1'b1);
        send(1, 32'd5, 5, 1'b1, 1'b1);

        // Full-scale positive samples over the largest window.
        i_log2_win = 3'd5;
        wait_clear("k5_clear_cycles");
        for (int i = 1; i <= 32; i++) begin
            send(2, 32'h7FFF_FFFF, (longint'(i) * 64'sh7FFF_FFFF) >>> 5, (i == 32), 1'b1);
        end

        // Reset while the ch3 slot is in UPDATE: no result for it.
        send(3, 32'd50, 0, 1'b0, 1'b0);
        @(negedge i_clock);
        i_RESET = 1'b0;
        i_log2_win = 3'd2;
        @(negedge i_clock);
        chk("midslot_reset_busy", longint'(o_busy), 64'sd1);
        chk("midslot_reset_valid", longint'(o_valid), 64'sd0);
        chk("midslot_reset_ch", longint'(o_ch), 64'sd0);
        chk("midslot_reset_mean", longint'(o_mean), 64'sd0);
        i_RESET = 1'b1;
        wait_clear("reset_clear_cycles");
        send(0, 32'd7, 1, 1'b0, 1'b1);
        send(0, 32'd7, 3, 1'b0, 1'b1);
        send(0, 32'd7, 5, 1'b0, 1'b1);
        send(0, 32'd7, 7, 1'b1, 1'b1);
        send(0, 32'd7, 7, 1'b1, 1'b1);

        repeat (12) @(negedge i_clock);
        chk("scoreboard_drained", longint'(q.size()), 64'sd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
